xor_hash_engine: RTL

- Consumer end of the hash_q matrix interface: the flat KEY_WIDTH x INDEX_WIDTH matrix bus produced by the hash_q provider blocks.
- Snapshots the matrix into internal registers on a load strobe.
- Hashes a stream of keys with the H3/XOR scheme: index = XOR of row i over every set key bit i.
- Sits between key ingress and the hash-table bank/URAM address path. Two-stage pipeline, valid/ready on both sides.

---
 rtl/xor_hash_pkg.sv | 18 +
 rtl/xor_hash_engine_if.sv | 33 +++
 rtl/xor_hash_partial.sv | 23 ++
 rtl/xor_hash_engine.sv | 111 +++++++++++
 4 files changed

// File: rtl/xor_hash_pkg.sv
// Shared constants and helpers for the H3/XOR hash matrix, common to the
// hash_q provider blocks and the xor_hash_engine consumer.
package xor_hash_pkg;

    localparam int DEF_KEY_WIDTH   = 32;
    localparam int DEF_INDEX_WIDTH = 12;
    localparam int DEF_TAG_WIDTH   = 8;
    localparam int DEF_MATRIX_WIDTH = DEF_KEY_WIDTH * DEF_INDEX_WIDTH;

    typedef logic [DEF_INDEX_WIDTH-1:0]  row_t;
    typedef logic [DEF_MATRIX_WIDTH-1:0] matrix_t;

    // Row i of the flat matrix bus lives at [INDEX_WIDTH*i +: INDEX_WIDTH].
    function automatic row_t row_slice(input matrix_t m, input int unsigned i);
        return m[DEF_INDEX_WIDTH*i +: DEF_INDEX_WIDTH];
    endfunction

endpackage

// File: rtl/xor_hash_engine_if.sv
// Matrix-load and key/result stream signals of the xor_hash_engine.
// Both streams use valid/ready: a transfer happens on a rising edge where
// valid and ready are both high; a raised valid and its payload must stay
// stable until that edge, and ready may depend combinationally on valid.
interface xor_hash_engine_if
    import xor_hash_pkg::*;
#(
    parameter int KEY_WIDTH   = DEF_KEY_WIDTH,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int TAG_WIDTH   = DEF_TAG_WIDTH
);
    logic [INDEX_WIDTH*KEY_WIDTH-1:0] hash_q_in;
    logic                             q_load;
    logic                             q_loaded;
    logic                             in_valid;
    logic                             in_ready;
    logic [KEY_WIDTH-1:0]             in_key;
    logic [TAG_WIDTH-1:0]             in_tag;
    logic                             out_valid;
    logic                             out_ready;
    logic [INDEX_WIDTH-1:0]           out_index;
    logic [TAG_WIDTH-1:0]             out_tag;

    modport master (
        output hash_q_in, q_load, in_valid, in_key, in_tag, out_ready,
        input  q_loaded, in_ready, out_valid, out_index, out_tag
    );

    modport slave (
        input  hash_q_in, q_load, in_valid, in_key, in_tag, out_ready,
        output q_loaded, in_ready, out_valid, out_index, out_tag
    );
endinterface

// File: rtl/xor_hash_partial.sv
// Combinational masked XOR reduction: XOR of every matrix row i in
// [ROW_LO, ROW_LO+ROW_CNT) whose key bit i is set.
module xor_hash_partial
    import xor_hash_pkg::*;
#(
    parameter int KEY_WIDTH   = DEF_KEY_WIDTH,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int ROW_LO      = 0,
    parameter int ROW_CNT     = DEF_KEY_WIDTH / 2
) (
    input  logic [KEY_WIDTH*INDEX_WIDTH-1:0] matrix,
    input  logic [KEY_WIDTH-1:0]             key,
    output logic [INDEX_WIDTH-1:0]           partial
);
    always_comb begin
        partial = '0;
        for (int i = 0; i < KEY_WIDTH; i++) begin
            if (i >= ROW_LO && i < ROW_LO + ROW_CNT && key[i]) begin
                partial = partial ^ matrix[INDEX_WIDTH*i +: INDEX_WIDTH];
            end
        end
    end
endmodule

// File: rtl/xor_hash_engine.sv
// H3/XOR hash engine: snapshots the hash_q matrix on q_load, then hashes a
// key stream through a two-stage pipeline (split partials, then final XOR).
module xor_hash_engine
    import xor_hash_pkg::*;
#(
    parameter int KEY_WIDTH   = DEF_KEY_WIDTH,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int TAG_WIDTH   = DEF_TAG_WIDTH
) (
    input logic               clk,
    input logic               rst,
    xor_hash_engine_if.slave  bus
);
    localparam int MW     = KEY_WIDTH * INDEX_WIDTH;
    localparam int LO_CNT = KEY_WIDTH / 2;
    localparam int HI_CNT = KEY_WIDTH - LO_CNT;

    logic [MW-1:0]          matrix_q, matrix_d;
    logic                   q_loaded_q, q_loaded_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [INDEX_WIDTH-1:0] s1_pa_q, s1_pa_d;
    logic [INDEX_WIDTH-1:0] s1_pb_q, s1_pb_d;
    logic [TAG_WIDTH-1:0]   s1_tag_q, s1_tag_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [INDEX_WIDTH-1:0] s2_index_q, s2_index_d;
    logic [TAG_WIDTH-1:0]   s2_tag_q, s2_tag_d;

    logic                   s2_free, s1_adv, in_ready, accept;
    logic [INDEX_WIDTH-1:0] pa, pb;

    // Partials always read the registered matrix; accept is blocked in the
    // q_load cycle, so an accepted key never sees a half-updated matrix.
    xor_hash_partial #(
        .KEY_WIDTH(KEY_WIDTH), .INDEX_WIDTH(INDEX_WIDTH),
        .ROW_LO(0), .ROW_CNT(LO_CNT)
    ) u_part_a (.matrix(matrix_q), .key(bus.in_key), .partial(pa));

    xor_hash_partial #(
        .KEY_WIDTH(KEY_WIDTH), .INDEX_WIDTH(INDEX_WIDTH),
        .ROW_LO(LO_CNT), .ROW_CNT(HI_CNT)
    ) u_part_b (.matrix(matrix_q), .key(bus.in_key), .partial(pb));

    always_comb begin
        s2_free  = ~s2_valid_q | bus.out_ready;
        s1_adv   = s1_valid_q & s2_free;
        in_ready = q_loaded_q & ~bus.q_load & (~s1_valid_q | s1_adv);
        accept   = bus.in_valid & in_ready;

        matrix_d   = matrix_q;
        q_loaded_d = q_loaded_q;
        s1_valid_d = s1_valid_q;
        s1_pa_d    = s1_pa_q;
        s1_pb_d    = s1_pb_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_index_d = s2_index_q;
        s2_tag_d   = s2_tag_q;

        if (bus.q_load) begin
            matrix_d   = bus.hash_q_in;
            q_loaded_d = 1'b1;
        end

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_pa_d    = pa;
            s1_pb_d    = pb;
            s1_tag_d   = bus.in_tag;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_index_d = s1_pa_q ^ s1_pb_q;
            s2_tag_d   = s1_tag_q;
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            matrix_q   <= '0;
            q_loaded_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_pa_q    <= '0;
            s1_pb_q    <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_index_q <= '0;
            s2_tag_q   <= '0;
        end else begin
            matrix_q   <= matrix_d;
            q_loaded_q <= q_loaded_d;
            s1_valid_q <= s1_valid_d;
            s1_pa_q    <= s1_pa_d;
            s1_pb_q    <= s1_pb_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_index_q <= s2_index_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.q_loaded  = q_loaded_q;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_index = s2_index_q;
    assign bus.out_tag   = s2_tag_q;
endmodule
